// File: rtl/scoreboard_scan_ctrl.sv
// Score RAM scanner: reads {userid, score} records until a sentinel or the end of
// the RAM, keeps a sorted top-N table, then steps through the ranks on a button.
module scoreboard_scan_ctrl #(
    parameter int          ADDR_W   = 4,
    parameter int          TOP_N    = 3,
    parameter logic [15:0] SENTINEL = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    input  logic              next_btn,
    output logic              busy,
    output logic              rank_valid,
    output logic [1:0]        rank_index,
    output logic [31:0]       userid_score_output,
    output logic              scoreboard_eof
);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, INSERT, DISPLAY, DONE
    } state_t;

    localparam logic [1:0] LAST_RANK = 2'(TOP_N - 1);

    state_t      state, state_n;
    logic [31:0] tbl      [TOP_N];
    logic [31:0] next_tbl [TOP_N];
    logic [31:0] rec;
    logic        btn_q;
    logic        btn_edge;
    logic        is_sentinel;
    logic        found;

    assign btn_edge    = next_btn & ~btn_q;
    assign is_sentinel = (mem_data[31:16] == SENTINEL);

    assign mem_rd     = (state == REQ);
    assign busy       = (state == REQ) || (state == WAIT) || (state == INSERT);
    assign rank_valid = (state == DISPLAY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (start) state_n = REQ;
            REQ:        state_n = WAIT;
            WAIT:       state_n = is_sentinel ? DISPLAY : INSERT;
            INSERT:     state_n = (mem_addr == '1) ? DISPLAY : REQ;
            DISPLAY:    if (btn_edge && rank_index == LAST_RANK) state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    // Strict '>' places the new record below any equal score already held,
    // so earlier-read records win ties; everything below the slot shifts down.
    always_comb begin
        found = 1'b0;
        next_tbl[0] = tbl[0];
        if (rec[15:0] > tbl[0][15:0]) begin
            next_tbl[0] = rec;
            found       = 1'b1;
        end
        for (int unsigned i = 1; i < TOP_N; i++) begin
            next_tbl[i] = tbl[i];
            if (found) begin
                next_tbl[i] = tbl[i-1];
            end else if (rec[15:0] > tbl[i][15:0]) begin
                next_tbl[i] = rec;
                found       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < TOP_N; i++) tbl[i] <= '0;
            rec                 <= '0;
            mem_addr            <= '0;
            rank_index          <= '0;
            userid_score_output <= '0;
            scoreboard_eof      <= 1'b0;
            btn_q               <= 1'b0;
        end else begin
            btn_q <= next_btn;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < TOP_N; i++) tbl[i] <= '0;
                        mem_addr       <= '0;
                        rank_index     <= '0;
                        scoreboard_eof <= 1'b0;
                    end
                end
                WAIT: begin
                    if (!is_sentinel) rec <= mem_data;
                end
                INSERT: begin
                    for (int unsigned i = 0; i < TOP_N; i++) tbl[i] <= next_tbl[i];
                    if (mem_addr != '1) mem_addr <= mem_addr + 1'b1;
                end
                DISPLAY: begin
                    if (btn_edge) begin
                        if (rank_index == LAST_RANK) begin
                            rank_index     <= '0;
                            scoreboard_eof <= 1'b1;
                        end else begin
                            rank_index <= rank_index + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            // Loaded only while staying in DISPLAY, so the table write on the
            // entry edge is never missed and DONE shows zero immediately.
            userid_score_output <= (state == DISPLAY && state_n == DISPLAY)
                                   ? tbl[rank_index] : '0;
        end
    end

endmodule
